// File: rtl/alu_seq_pkg.sv
// Shared definitions for the registered ALU: opcodes, flag bit positions,
// control states and a small flag-packing helper.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_SHL  = 4'd4,
    OP_SHR  = 4'd5,
    OP_ROL  = 4'd6,
    OP_ROR  = 4'd7,
    OP_AND  = 4'd8,
    OP_OR   = 4'd9,
    OP_XOR  = 4'd10,
    OP_NOR  = 4'd11,
    OP_NAND = 4'd12,
    OP_XNOR = 4'd13,
    OP_GT   = 4'd14,
    OP_EQ   = 4'd15
  } alu_op_e;

  // FLAGS bus is {ERR,V,C,N,Z}
  localparam int FLAG_W   = 5;
  localparam int FLAG_Z   = 0;
  localparam int FLAG_N   = 1;
  localparam int FLAG_C   = 2;
  localparam int FLAG_V   = 3;
  localparam int FLAG_ERR = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  function automatic logic [FLAG_W-1:0] pack_flags(input logic err, input logic v,
                                                   input logic c, input logic n,
                                                   input logic z);
    logic [FLAG_W-1:0] f;
    f           = '0;
    f[FLAG_ERR] = err;
    f[FLAG_V]   = v;
    f[FLAG_C]   = c;
    f[FLAG_N]   = n;
    f[FLAG_Z]   = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned multiplier / divider. One bit per cycle: shift-add for
// multiply, restoring division for divide. The final step is presented
// combinationally together with done so the caller registers it on that edge.
module alu_seq_muldiv
  import alu_seq_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             hi_nonzero
);

  logic             run_reg;
  logic             div_reg;
  logic [SHW-1:0]   count_reg;
  // acc_reg: product high half (MUL) or partial remainder (DIV)
  // lo_reg : multiplier shifting out / product low half (MUL) or dividend->quotient (DIV)
  // opnd_reg: multiplicand (MUL) or divisor (DIV)
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] lo_reg;
  logic [WIDTH-1:0] opnd_reg;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shifted;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] lo_step;

  // One iteration of whichever algorithm is loaded
  always_comb begin
    mul_sum     = {1'b0, acc_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
    div_shifted = {acc_reg, lo_reg[WIDTH-1]};
    div_trial   = div_shifted - {1'b0, opnd_reg};
    acc_step    = acc_reg;
    lo_step     = lo_reg;
    if (div_reg) begin
      // trial[WIDTH] set means the subtraction went negative: restore
      if (!div_trial[WIDTH]) begin
        acc_step = div_trial[WIDTH-1:0];
        lo_step  = {lo_reg[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = div_shifted[WIDTH-1:0];
        lo_step  = {lo_reg[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_step = mul_sum[WIDTH:1];
      lo_step  = {mul_sum[0], lo_reg[WIDTH-1:1]};
    end
  end

  assign done       = run_reg && (count_reg == SHW'(WIDTH - 1));
  assign result     = lo_step;
  assign hi_nonzero = |acc_step;

  // Operand load on start, then WIDTH iterations; rst aborts mid-operation
  always_ff @(posedge clk) begin
    if (rst) begin
      run_reg   <= 1'b0;
      div_reg   <= 1'b0;
      count_reg <= '0;
      acc_reg   <= '0;
      lo_reg    <= '0;
      opnd_reg  <= '0;
    end else if (start) begin
      run_reg   <= 1'b1;
      div_reg   <= op_div;
      count_reg <= '0;
      acc_reg   <= '0;
      lo_reg    <= op_div ? a : b;
      opnd_reg  <= op_div ? b : a;
    end else if (run_reg) begin
      acc_reg   <= acc_step;
      lo_reg    <= lo_step;
      count_reg <= count_reg + SHW'(1);
      if (done) begin
        run_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered 16-opcode ALU with valid/ready handshakes on both sides,
// status flags and an iterative MUL/DIV engine. One operation in flight;
// the result is held until the sink takes it.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic [3:0]        ALU_SEL,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [WIDTH-1:0]  ALU_RES,
  output logic [FLAG_W-1:0] FLAGS
);

  state_e            state_reg, state_next;
  logic [WIDTH-1:0]  res_reg, res_next;
  logic [FLAG_W-1:0] flags_reg, flags_next;
  logic              div_reg, div_next;

  alu_op_e          op_in;
  logic             fire;
  logic             iter_op;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_result;
  logic             md_hi_nz;

  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH:0]   shl_w;
  logic [WIDTH:0]   shr_w;
  logic [WIDTH-1:0] rol_w;
  logic [WIDTH-1:0] ror_w;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_v, sc_err;

  assign op_in     = alu_op_e'(ALU_SEL);
  assign IN_READY  = (state_reg == ST_IDLE) || ((state_reg == ST_HOLD) && OUT_READY);
  assign OUT_VALID = (state_reg == ST_HOLD);
  assign ALU_RES   = res_reg;
  assign FLAGS     = flags_reg;
  assign fire      = IN_VALID && IN_READY;
  // DIV by zero skips the iterative engine and finishes like a single-cycle op
  assign iter_op   = (op_in == OP_MUL) || ((op_in == OP_DIV) && (B != '0));

  assign shamt = B[SHW-1:0];
  assign add_w = {1'b0, A} + {1'b0, B};
  assign sub_w = {1'b0, A} - {1'b0, B};
  // Extra bit catches the last bit shifted out (stays 0 for amount 0)
  assign shl_w = {1'b0, A} << shamt;
  assign shr_w = {A, 1'b0} >> shamt;

  // Rotates: index arithmetic in SHW bits wraps modulo WIDTH
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rot
    localparam logic [SHW-1:0] IDX = SHW'(gi);
    assign rol_w[gi] = A[IDX - shamt];
    assign ror_w[gi] = A[IDX + shamt];
  end

  // Single-cycle result and C/V/ERR for the operands currently presented
  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_err = 1'b0;
    case (op_in)
      OP_ADD: begin
        sc_res = add_w[WIDTH-1:0];
        sc_c   = add_w[WIDTH];
        sc_v   = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = sub_w[WIDTH-1:0];
        sc_c   = sub_w[WIDTH];
        sc_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_DIV: begin
        sc_res = '1;
        sc_err = 1'b1;
      end
      OP_SHL: begin
        sc_res = shl_w[WIDTH-1:0];
        sc_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        sc_res = shr_w[WIDTH:1];
        sc_c   = shr_w[0];
      end
      OP_ROL:  sc_res = rol_w;
      OP_ROR:  sc_res = ror_w;
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_XOR:  sc_res = A ^ B;
      OP_NOR:  sc_res = ~(A | B);
      OP_NAND: sc_res = ~(A & B);
      OP_XNOR: sc_res = ~(A ^ B);
      OP_GT:   sc_res = WIDTH'(A > B);
      OP_EQ:   sc_res = WIDTH'(A == B);
      default: sc_res = '0;
    endcase
  end

  // Control FSM: accept, iterate, hold result until drained
  always_comb begin
    state_next = state_reg;
    res_next   = res_reg;
    flags_next = flags_reg;
    div_next   = div_reg;
    md_start   = 1'b0;
    case (state_reg)
      ST_IDLE, ST_HOLD: begin
        if (fire) begin
          if (iter_op) begin
            md_start   = 1'b1;
            div_next   = (op_in == OP_DIV);
            state_next = ST_BUSY;
          end else begin
            res_next   = sc_res;
            flags_next = pack_flags(sc_err, sc_v, sc_c, sc_res[WIDTH-1], sc_res == '0);
            state_next = ST_HOLD;
          end
        end else if ((state_reg == ST_HOLD) && OUT_READY) begin
          state_next = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (md_done) begin
          res_next   = md_result;
          flags_next = pack_flags(1'b0, 1'b0, !div_reg && md_hi_nz,
                                  md_result[WIDTH-1], md_result == '0);
          state_next = ST_HOLD;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      res_reg   <= '0;
      flags_reg <= '0;
      div_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      res_reg   <= res_next;
      flags_reg <= flags_next;
      div_reg   <= div_next;
    end
  end

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .start     (md_start),
    .op_div    (op_in == OP_DIV),
    .a         (A),
    .b         (B),
    .done      (md_done),
    .result    (md_result),
    .hi_nonzero(md_hi_nz)
  );

endmodule
